// File: rtl/timingskew_clocked.sv
// Clocked per-channel edge skew: delays selected edges of each input by a
// programmable number of clk cycles, swallowing pulses shorter than the skew.
module timingskew_clocked #(
    parameter int NCH        = 4,
    parameter int SEL_W      = 4,
    parameter int LSB_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH-1:0]       in,
    input  logic [NCH*SEL_W-1:0] s,
    input  logic [1:0]           edge_sel,
    output logic [NCH-1:0]       out,
    output logic [NCH-1:0]       busy,
    output logic [NCH-1:0]       swallow
);
    // Wide enough that code * LSB_CYCLES never overflows.
    localparam int CW = SEL_W + $clog2(LSB_CYCLES) + 1;

    typedef enum logic {IDLE, WAIT} state_t;

    logic [NCH-1:0] in_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) in_q <= '0;
        else     in_q <= in;
    end

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        state_t        state, state_nxt;
        logic [CW-1:0] cnt, cnt_nxt, dly;
        logic          target, target_nxt;
        logic          out_r, out_nxt;
        logic          busy_r, busy_nxt;
        logic          swallow_r, swallow_nxt;
        logic          sel_edge;

        assign dly = CW'(s[c*SEL_W +: SEL_W]) * CW'(LSB_CYCLES);

        always_comb begin
            sel_edge = 1'b0;
            unique case (edge_sel)
                2'd0: sel_edge = in_q[c];
                2'd1: sel_edge = ~in_q[c];
                2'd2: sel_edge = 1'b1;
                2'd3: sel_edge = 1'b0;
            endcase
        end

        always_comb begin
            state_nxt   = state;
            cnt_nxt     = cnt;
            target_nxt  = target;
            out_nxt     = out_r;
            busy_nxt    = busy_r;
            swallow_nxt = 1'b0;
            unique case (state)
                IDLE: begin
                    if (in_q[c] != out_r) begin
                        if (sel_edge && dly != '0) begin
                            state_nxt  = WAIT;
                            cnt_nxt    = dly - CW'(1);
                            target_nxt = in_q[c];
                            busy_nxt   = 1'b1;
                        end else begin
                            out_nxt = in_q[c];
                        end
                    end
                end
                WAIT: begin
                    // Cancel wins over expiry on the same edge.
                    if (in_q[c] == out_r) begin
                        state_nxt   = IDLE;
                        busy_nxt    = 1'b0;
                        swallow_nxt = 1'b1;
                    end else if (cnt == '0) begin
                        state_nxt = IDLE;
                        out_nxt   = target;
                        busy_nxt  = 1'b0;
                    end else begin
                        cnt_nxt = cnt - CW'(1);
                    end
                end
            endcase
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state     <= IDLE;
                cnt       <= '0;
                target    <= 1'b0;
                out_r     <= 1'b0;
                busy_r    <= 1'b0;
                swallow_r <= 1'b0;
            end else begin
                state     <= state_nxt;
                cnt       <= cnt_nxt;
                target    <= target_nxt;
                out_r     <= out_nxt;
                busy_r    <= busy_nxt;
                swallow_r <= swallow_nxt;
            end
        end

        assign out[c]     = out_r;
        assign busy[c]    = busy_r;
        assign swallow[c] = swallow_r;
    end
endmodule

// File: tb/tb_timingskew_clocked.sv
// Directed bench for timingskew_clocked with default parameters
// (NCH=4, SEL_W=4, LSB_CYCLES=2).
module tb_timingskew_clocked;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  in;
    logic [15:0] s;
    logic [1:0]  edge_sel;
    logic [3:0]  out, busy, swallow;

    int checks = 0;
    int errors = 0;
    logic exp1;

    timingskew_clocked dut (
        .clk(clk), .rst(rst), .in(in), .s(s), .edge_sel(edge_sel),
        .out(out), .busy(busy), .swallow(swallow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; in = '0; s = '0; edge_sel = 2'd0;
        #2;
        check("reset_out", 32'(out), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_swallow", 32'(swallow), 0);
        tick(); tick();
        rst = 1'b0;
        tick(); tick();
        check("idle_out", 32'(out), 0);

        // Rise skew: s0=3 -> D=6, out rises at k+7
        s[3:0] = 4'd3; edge_sel = 2'd0;
        in[0] = 1'b1;
        tick();                                   // k
        check("rise_busy_k", 32'(busy[0]), 0);
        tick();                                   // k+1
        check("rise_busy_k1", 32'(busy[0]), 1);
        for (int i = 2; i <= 6; i++) begin
            tick();
            check("rise_out_wait", 32'(out[0]), 0);
        end
        tick();                                   // k+7
        check("rise_out_k7", 32'(out[0]), 1);
        check("rise_busy_k7", 32'(busy[0]), 0);
        in[0] = 1'b0;
        tick();                                   // m
        check("fall_out_m", 32'(out[0]), 1);
        tick();                                   // m+1
        check("fall_out_m1", 32'(out[0]), 0);
        check("fall_busy_m1", 32'(busy[0]), 0);

        // Short pulse: s0=5 -> D=10, input high for 4 cycles
        s[3:0] = 4'd5;
        in[0] = 1'b1;
        tick(); tick(); tick(); tick();           // k..k+3
        in[0] = 1'b0;
        tick();                                   // k+4
        check("pulse_busy_k4", 32'(busy[0]), 1);
        check("pulse_swallow_k4", 32'(swallow[0]), 0);
        tick();                                   // k+5
        check("pulse_swallow_k5", 32'(swallow[0]), 1);
        check("pulse_busy_k5", 32'(busy[0]), 0);
        check("pulse_out_k5", 32'(out[0]), 0);
        tick();
        check("pulse_swallow_k6", 32'(swallow[0]), 0);
        for (int i = 0; i < 12; i++) begin
            tick();
            check("pulse_out_steady", 32'(out[0]), 0);
        end

        // Both mode with s1=0: 1-cycle latency, never busy
        edge_sel = 2'd2; s[7:4] = 4'd0;
        exp1 = 1'b0;
        for (int t = 0; t < 4; t++) begin
            in[1] = ~in[1];
            tick();
            check("both_out_old", 32'(out[1]), 32'(exp1));
            exp1 = in[1];
            tick();
            check("both_out_new", 32'(out[1]), 32'(exp1));
            check("both_busy", 32'(busy[1]), 0);
            tick();
            check("both_out_hold", 32'(out[1]), 32'(exp1));
        end

        // Code change mid-WAIT: s2=4 captured -> D=8, out rises at k+9
        edge_sel = 2'd0; s[11:8] = 4'd4;
        in[2] = 1'b1;
        tick();                                   // k
        tick();                                   // k+1
        check("chg_busy", 32'(busy[2]), 1);
        tick();                                   // k+2
        s[11:8] = 4'd1;
        for (int i = 3; i <= 8; i++) begin
            tick();
            check("chg_out_wait", 32'(out[2]), 0);
        end
        tick();                                   // k+9
        check("chg_out_k9", 32'(out[2]), 1);
        check("chg_busy_k9", 32'(busy[2]), 0);
        in[2] = 1'b0;
        tick(); tick();
        check("chg_fall", 32'(out[2]), 0);

        // Independence/bypass: ch0 waiting (rise, D=6) while ch3 bypasses
        s[3:0] = 4'd3; s[15:12] = 4'd7;
        in[0] = 1'b1;
        tick();                                   // k
        tick();                                   // k+1
        check("ind_busy0", 32'(busy[0]), 1);
        edge_sel = 2'd3;
        in[3] = 1'b1;
        tick();                                   // k+2
        check("byp_out3_old", 32'(out[3]), 0);
        tick();                                   // k+3
        check("byp_out3_new", 32'(out[3]), 1);
        check("byp_busy3", 32'(busy[3]), 0);
        in[3] = 1'b0;
        tick();                                   // k+4
        check("byp_out3_hold", 32'(out[3]), 1);
        tick();                                   // k+5
        check("byp_out3_fall", 32'(out[3]), 0);
        tick();                                   // k+6
        check("ind_out0_k6", 32'(out[0]), 0);
        tick();                                   // k+7
        check("ind_out0_k7", 32'(out[0]), 1);

        // Reset mid-WAIT on a falling edge
        edge_sel = 2'd1;
        in[0] = 1'b0;
        tick(); tick();
        check("rst_pre_busy", 32'(busy[0]), 1);
        check("rst_pre_out", 32'(out[0]), 1);
        #2 rst = 1'b1;
        #1;
        check("rst_async_out", 32'(out), 0);
        check("rst_async_busy", 32'(busy), 0);
        check("rst_async_swallow", 32'(swallow), 0);
        tick();
        rst = 1'b0; in = '0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("post_rst_out", 32'(out), 0);
            check("post_rst_busy", 32'(busy), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
